// File: rtl/ov5640_fb_pkg.sv
// Shared types and bank-selection helper for the OV5640 frame-buffer write scheduler.
package ov5640_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_VS,
    ST_CAPTURE
  } fb_state_t;

  localparam int BANK_W    = 2;
  localparam int NUM_BANKS = 3;

  // Lowest bank index owned neither by the newest published frame nor by the reader.
  function automatic logic [BANK_W-1:0] next_wr_bank(
    input logic [BANK_W-1:0] latest,
    input logic              latest_valid,
    input logic [BANK_W-1:0] rd
  );
    logic [BANK_W-1:0] sel;
    sel = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!(latest_valid && (BANK_W'(i) == latest)) && (BANK_W'(i) != rd)) begin
        sel = BANK_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ov5640_frame_ctrl.sv
// Triple-buffered frame capture scheduler: skips settling frames, writes pixels into a
// free bank, publishes only complete frames and hands the newest one to the reader.
module ov5640_frame_ctrl
  import ov5640_fb_pkg::*;
#(
  parameter int H_PIXELS    = 480,
  parameter int V_LINES     = 272,
  parameter int SKIP_FRAMES = 10,
  parameter int ADDR_W      = 17
) (
  input  logic              cmos_pclk,
  input  logic              sys_rst,
  input  logic              cfg_done,
  input  logic              sys_init_done,
  input  logic              cmos_vsync,
  input  logic              ov5640_wr_en,
  input  logic [15:0]       cmos_16bit_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [15:0]       fb_wr_data,
  output logic [BANK_W-1:0] wr_bank,
  output logic              frame_done,
  output logic              frame_err,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [BANK_W-1:0] rd_bank,
  output logic              rd_new
);

  localparam logic [ADDR_W:0] N_WORDS   = (ADDR_W + 1)'(H_PIXELS * V_LINES);
  localparam logic [7:0]      SKIP_LAST = 8'(SKIP_FRAMES);

  fb_state_t         state_reg, state_next;
  logic [7:0]        skip_reg, skip_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              ovr_reg, ovr_next;
  logic              vsync_q_reg;
  logic [BANK_W-1:0] wr_bank_reg, wr_bank_next;
  logic [BANK_W-1:0] rd_bank_reg, rd_bank_next;
  logic [BANK_W-1:0] latest_bank_reg, latest_bank_next;
  logic              latest_valid_reg, latest_valid_next;
  logic              fb_wr_en_reg, fb_wr_en_next;
  logic [ADDR_W-1:0] fb_wr_addr_reg, fb_wr_addr_next;
  logic [15:0]       fb_wr_data_reg, fb_wr_data_next;
  logic              frame_done_reg, frame_done_next;
  logic              frame_err_reg, frame_err_next;
  logic              rd_ack_reg;
  logic              rd_new_reg, rd_new_next;

  logic              enable;
  logic              vs_rise;
  logic              capture_pix;
  logic              publish;
  logic [ADDR_W:0]   base_cnt;
  logic              base_ovr;

  assign enable  = cfg_done & sys_init_done;
  assign vs_rise = cmos_vsync & ~vsync_q_reg;

  always_ff @(posedge cmos_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg        <= ST_IDLE;
      skip_reg         <= '0;
      cnt_reg          <= '0;
      ovr_reg          <= 1'b0;
      vsync_q_reg      <= 1'b0;
      wr_bank_reg      <= 2'd0;
      rd_bank_reg      <= 2'd2;
      latest_bank_reg  <= 2'd1;
      latest_valid_reg <= 1'b0;
      fb_wr_en_reg     <= 1'b0;
      fb_wr_addr_reg   <= '0;
      fb_wr_data_reg   <= '0;
      frame_done_reg   <= 1'b0;
      frame_err_reg    <= 1'b0;
      rd_ack_reg       <= 1'b0;
      rd_new_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      skip_reg         <= skip_next;
      cnt_reg          <= cnt_next;
      ovr_reg          <= ovr_next;
      vsync_q_reg      <= cmos_vsync;
      wr_bank_reg      <= wr_bank_next;
      rd_bank_reg      <= rd_bank_next;
      latest_bank_reg  <= latest_bank_next;
      latest_valid_reg <= latest_valid_next;
      fb_wr_en_reg     <= fb_wr_en_next;
      fb_wr_addr_reg   <= fb_wr_addr_next;
      fb_wr_data_reg   <= fb_wr_data_next;
      frame_done_reg   <= frame_done_next;
      frame_err_reg    <= frame_err_next;
      rd_ack_reg       <= rd_req;
      rd_new_reg       <= rd_new_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    skip_next         = skip_reg;
    cnt_next          = cnt_reg;
    ovr_next          = ovr_reg;
    wr_bank_next      = wr_bank_reg;
    rd_bank_next      = rd_bank_reg;
    latest_bank_next  = latest_bank_reg;
    latest_valid_next = latest_valid_reg;
    fb_wr_en_next     = 1'b0;
    fb_wr_addr_next   = fb_wr_addr_reg;
    fb_wr_data_next   = fb_wr_data_reg;
    frame_done_next   = 1'b0;
    frame_err_next    = 1'b0;
    rd_new_next       = 1'b0;
    capture_pix       = 1'b0;
    publish           = 1'b0;
    base_cnt          = cnt_reg;
    base_ovr          = ovr_reg;

    if (!enable) begin
      state_next        = ST_IDLE;
      latest_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          skip_next  = '0;
          state_next = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;
        end
        ST_SKIP: begin
          if (vs_rise) begin
            if (skip_reg + 8'd1 == SKIP_LAST) state_next = ST_WAIT_VS;
            else                              skip_next  = skip_reg + 8'd1;
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) begin
            state_next  = ST_CAPTURE;
            capture_pix = 1'b1;
            base_cnt    = '0;
            base_ovr    = 1'b0;
          end
        end
        ST_CAPTURE: begin
          capture_pix = 1'b1;
          // vsync closes the current frame and opens the next one in the same cycle
          if (vs_rise) begin
            if (cnt_reg == N_WORDS && !ovr_reg) begin
              publish           = 1'b1;
              latest_bank_next  = wr_bank_reg;
              latest_valid_next = 1'b1;
              frame_done_next   = 1'b1;
            end else begin
              frame_err_next = 1'b1;
            end
            base_cnt = '0;
            base_ovr = 1'b0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    if (capture_pix) begin
      cnt_next = base_cnt;
      ovr_next = base_ovr;
      if (ov5640_wr_en) begin
        if (base_cnt < N_WORDS) begin
          fb_wr_en_next   = 1'b1;
          fb_wr_addr_next = base_cnt[ADDR_W-1:0];
          fb_wr_data_next = cmos_16bit_data;
          cnt_next        = base_cnt + (ADDR_W + 1)'(1);
        end else begin
          ovr_next = 1'b1;
        end
      end
    end

    // Handover sees a same-cycle publish; bank choice then sees the updated reader bank
    if (rd_req && latest_valid_next && (latest_bank_next != rd_bank_reg)) begin
      rd_bank_next = latest_bank_next;
      rd_new_next  = 1'b1;
    end
    if (publish) begin
      wr_bank_next = next_wr_bank(latest_bank_next, latest_valid_next, rd_bank_next);
    end
  end

  assign fb_wr_en   = fb_wr_en_reg;
  assign fb_wr_addr = fb_wr_addr_reg;
  assign fb_wr_data = fb_wr_data_reg;
  assign wr_bank    = wr_bank_reg;
  assign rd_bank    = rd_bank_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign rd_ack     = rd_ack_reg;
  assign rd_new     = rd_new_reg;

endmodule
